// File: rtl/booth_dot_product_seq.sv
// Sequencer around an 8-bit Booth multiplier: it accumulates a signed dot product over operand pairs
// until in_last. Saturating accumulation is enabled by defining BOOTH_DOT_SATURATE_EN.
module booth_dot_product_seq #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic [7:0]       mul_m,
  output logic [7:0]       mul_r,
  output logic             mul_start,
  input  logic             mul_ready,
  input  logic [15:0]      mul_ans,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    ACCUM     = 3'd4,
    OUT       = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        m_q, m_d;
  logic [7:0]        r_q, r_d;
  logic              last_q, last_d;
  logic              start_q, start_d;
  logic [15:0]       prod_q, prod_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic signed [ACC_W-1:0] prod_ext;
  logic        [ACC_W:0]   sum_w;
  logic                    add_ovf;
  logic        [ACC_W-1:0] add_res;

  // One guard bit above ACC_W: overflow is when it disagrees with the ACC_W-bit sign.
  assign prod_ext = ACC_W'($signed(prod_q));
  assign sum_w    = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
  assign add_ovf  = sum_w[ACC_W] ^ sum_w[ACC_W-1];

`ifdef BOOTH_DOT_SATURATE_EN
  always_comb begin
    add_res = sum_w[ACC_W-1:0];
    if (add_ovf) begin
      add_res = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign add_res = sum_w[ACC_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    r_d     = r_q;
    last_d  = last_q;
    start_d = 1'b0;
    prod_d  = prod_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = in_a;
          r_d     = in_b;
          last_d  = in_last;
          state_d = ISSUE;
        end
      end
      // The start pulse is registered, so it appears in the first WAIT_BUSY cycle.
      ISSUE: begin
        if (mul_ready) begin
          start_d = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!mul_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (mul_ready) begin
          prod_d  = mul_ans;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d   = add_res;
        cnt_d   = cnt_q + 1'b1;
        ovf_d   = ovf_q | add_ovf;
        state_d = last_q ? OUT : IDLE;
      end
      OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      r_q     <= '0;
      last_q  <= 1'b0;
      start_q <= 1'b0;
      prod_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      r_q     <= r_d;
      last_q  <= last_d;
      start_q <= start_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign mul_m     = m_q;
  assign mul_r     = r_q;
  assign mul_start = start_q;
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_booth_dot_product_seq.sv
// Directed bench for booth_dot_product_seq: instance 0 uses ACC_W=24, instance 1 uses ACC_W=16 for overflow.
module tb_booth_dot_product_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [7:0]  in_a      [2];
  logic [7:0]  in_b      [2];
  logic        in_last   [2];
  logic [7:0]  mul_m     [2];
  logic [7:0]  mul_r     [2];
  logic        mul_start [2];
  logic        mul_ready [2];
  logic [15:0] mul_ans   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [7:0]  out_count [2];
  logic        out_ovf   [2];
  logic        hold_off  [2];
  logic [23:0] out_sum0;
  logic [15:0] out_sum1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  booth_dot_product_seq #(.ACC_W(24), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
    .in_last(in_last[0]), .mul_m(mul_m[0]), .mul_r(mul_r[0]), .mul_start(mul_start[0]),
    .mul_ready(mul_ready[0]), .mul_ans(mul_ans[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_sum(out_sum0), .out_count(out_count[0]), .out_ovf(out_ovf[0])
  );

  booth_dot_product_seq #(.ACC_W(16), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
    .in_last(in_last[1]), .mul_m(mul_m[1]), .mul_r(mul_r[1]), .mul_start(mul_start[1]),
    .mul_ready(mul_ready[1]), .mul_ans(mul_ans[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_sum(out_sum1), .out_count(out_count[1]), .out_ovf(out_ovf[1])
  );

  // Multiplier stand-in: product formed from the live m/r at completion; counts protocol violations.
  for (genvar g = 0; g < 2; g++) begin : g_mul
    logic               busy_q = 1'b0;
    logic [3:0]         cyc_q = '0;
    logic [7:0]         m_l = '0;
    logic [7:0]         r_l = '0;
    logic [15:0]        ans_q = '0;
    logic signed [15:0] prod_w;
    int                 err_q = 0;

    assign prod_w       = $signed(mul_m[g]) * $signed(mul_r[g]);
    assign mul_ans[g]   = ans_q;
    assign mul_ready[g] = ~busy_q & ~hold_off[g];

    always_ff @(posedge clk) begin
      if (rst) begin
        busy_q <= 1'b0;
        cyc_q  <= '0;
        ans_q  <= '0;
      end else if (busy_q) begin
        if (mul_start[g] || mul_m[g] !== m_l || mul_r[g] !== r_l) err_q <= err_q + 1;
        cyc_q <= cyc_q + 4'd1;
        if (cyc_q == 4'd6) begin
          busy_q <= 1'b0;
          ans_q  <= prod_w;
        end
      end else if (mul_start[g]) begin
        if (!mul_ready[g]) begin
          err_q <= err_q + 1;
        end else begin
          busy_q <= 1'b1;
          cyc_q  <= '0;
          m_l    <= mul_m[g];
          r_l    <= mul_r[g];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] sum_of(input int s);
    return (s == 0) ? 32'($signed(out_sum0)) : 32'($signed(out_sum1));
  endfunction

  task automatic put(input int s, input int a, input int b, input logic last);
    in_valid[s] = 1'b1;
    in_a[s]     = 8'(a);
    in_b[s]     = 8'(b);
    in_last[s]  = last;
  endtask

  task automatic wait_accept(input int s, output int waited);
    waited = 0;
    while (!in_ready[s] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_ready", {31'b0, in_ready[s]}, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid[s] = 1'b0;
  endtask

  task automatic send(input int s, input int a, input int b, input logic last, output int waited);
    put(s, a, b, last);
    wait_accept(s, waited);
  endtask

  task automatic wait_out(input int s, input string tag, input int sum, input int cnt, input logic ovf);
    for (int i = 0; i < 100 && !out_valid[s]; i++) @(negedge clk);
    chk({tag, "_valid"}, {31'b0, out_valid[s]}, 1);
    chk({tag, "_sum"}, sum_of(s), sum);
    chk({tag, "_count"}, {24'b0, out_count[s]}, cnt);
    chk({tag, "_ovf"}, {31'b0, out_ovf[s]}, {31'b0, ovf});
  endtask

  task automatic ack(input int s, input string tag);
    chk({tag, "_busy_in_ready"}, {31'b0, in_ready[s]}, 0);
    out_ready[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[s] = 1'b0;
    chk({tag, "_post_valid"}, {31'b0, out_valid[s]}, 0);
    chk({tag, "_post_in_ready"}, {31'b0, in_ready[s]}, 1);
  endtask

  initial begin
    int w;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_a[i] = '0; in_b[i] = '0; in_last[i] = 1'b0;
      out_ready[i] = 1'b0; hold_off[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready",  {31'b0, in_ready[0]}, 1);
    chk("rst_out_valid", {31'b0, out_valid[0]}, 0);
    chk("rst_mul_start", {31'b0, mul_start[0]}, 0);
    chk("rst_mul_m",     {24'b0, mul_m[0]}, 0);
    chk("rst_mul_r",     {24'b0, mul_r[0]}, 0);
    chk("rst_out_sum",   sum_of(0), 0);
    chk("rst_out_count", {24'b0, out_count[0]}, 0);
    chk("rst_out_ovf",   {31'b0, out_ovf[0]}, 0);
    chk("rst1_in_ready", {31'b0, in_ready[1]}, 1);

    // {(3,4),(-5,6),(7,-8)}: 12 - 30 - 56 = -74
    send(0, 3, 4, 1'b0, w);
    send(0, -5, 6, 1'b0, w);
    chk("a2a_2_le16", {31'b0, (w + 1) <= 16}, 1);
    send(0, 7, -8, 1'b1, w);
    chk("a2a_3_le16", {31'b0, (w + 1) <= 16}, 1);
    wait_out(0, "v1", -74, 3, 1'b0);
    ack(0, "v1");

    send(0, -128, -128, 1'b1, w);
    wait_out(0, "negneg", 16384, 1, 1'b0);
    ack(0, "negneg");

    // Multiplier not ready: no start may be issued, operands must hold.
    hold_off[0] = 1'b1;
    send(0, -128, 127, 1'b1, w);
    repeat (6) begin
      @(negedge clk);
      chk("stall_no_start", {31'b0, mul_start[0]}, 0);
    end
    chk("stall_m", {24'b0, mul_m[0]}, 32'h80);
    chk("stall_r", {24'b0, mul_r[0]}, 32'h7f);
    hold_off[0] = 1'b0;
    wait_out(0, "negpos", -16256, 1, 1'b0);
    ack(0, "negpos");

    // out_ready outside OUT must not clear the running sum: 100 - 5 = 95
    out_ready[0] = 1'b1;
    send(0, 10, 10, 1'b0, w);
    repeat (3) begin
      @(negedge clk);
      chk("early_ack_valid", {31'b0, out_valid[0]}, 0);
    end
    out_ready[0] = 1'b0;
    send(0, -1, 5, 1'b1, w);
    wait_out(0, "early_ack", 95, 2, 1'b0);
    ack(0, "early_ack");

    // Backpressure with the next pair waiting: 2 + 9 = 11, then 9 * -3 = -27
    send(0, 1, 2, 1'b0, w);
    send(0, 3, 3, 1'b1, w);
    wait_out(0, "bp", 11, 2, 1'b0);
    put(0, 9, -3, 1'b1);
    repeat (20) begin
      @(negedge clk);
      chk("bp_valid",    {31'b0, out_valid[0]}, 1);
      chk("bp_in_ready", {31'b0, in_ready[0]}, 0);
      chk("bp_sum",      sum_of(0), 11);
      chk("bp_count",    {24'b0, out_count[0]}, 2);
    end
    ack(0, "bp");
    wait_accept(0, w);
    wait_out(0, "bp_next", -27, 1, 1'b0);
    ack(0, "bp_next");

    // Reset while the second element's product is pending.
    send(0, 1, 1, 1'b0, w);
    send(0, 5, 5, 1'b0, w);
    for (int i = 0; i < 50 && mul_ready[0]; i++) @(negedge clk);
    chk("mid_busy", {31'b0, mul_ready[0]}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready",  {31'b0, in_ready[0]}, 1);
    chk("mid_rst_out_valid", {31'b0, out_valid[0]}, 0);
    chk("mid_rst_mul_start", {31'b0, mul_start[0]}, 0);
    chk("mid_rst_sum",       sum_of(0), 0);
    send(0, 2, 2, 1'b1, w);
    wait_out(0, "after_rst", 4, 1, 1'b0);
    ack(0, "after_rst");

    // 16-bit accumulator: 3 * 16129 = 48387 overflows.
    send(1, 127, 127, 1'b0, w);
    send(1, 127, 127, 1'b0, w);
    send(1, 127, 127, 1'b1, w);
`ifdef BOOTH_DOT_SATURATE_EN
    wait_out(1, "ovf16", 32767, 3, 1'b1);
`else
    wait_out(1, "ovf16", -17149, 3, 1'b1);
`endif
    ack(1, "ovf16");
    send(1, 1, 1, 1'b1, w);
    wait_out(1, "ovf_cleared", 1, 1, 1'b0);
    ack(1, "ovf_cleared");

    chk("proto0", g_mul[0].err_q, 0);
    chk("proto1", g_mul[1].err_q, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_dot_product_seq.md
Name: booth_dot_product_seq

Overview:
- Sequencing stage wrapped around the 8-bit booth_multiplier: drives its m/r/start inputs and consumes its 16-bit signed product via the ready handshake.
- Accepts a stream of signed 8-bit operand pairs terminated by a last flag and accumulates the products into a signed dot product.
- Presents the sum plus element count and overflow flag on a valid/ready output port.
- Sits between the operand source (DMA/host regs) and the result consumer.

Parameters:
ACC_W, 24, accumulator/result width in bits (two's complement, ≥16)
CNT_W, 8, element counter width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block accepts operand pair
in_a  input  8  signed multiplicand
in_b  input  8  signed multiplier
in_last  input  1  final pair of current vector
mul_m  output  8  to multiplier m
mul_r  output  8  to multiplier r
mul_start  output  1  to multiplier start
mul_ready  input  1  from multiplier ready
mul_ans  input  16  from multiplier ans (signed product)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  ACC_W  signed dot product
out_count  output  CNT_W  number of pairs in vector
out_ovf  output  1  sticky overflow seen in this vector

Behaviour:
- Reset (sync, rst=1 at an edge): state IDLE; in_ready=1; mul_start=0; mul_m=mul_r=0; out_valid=0; out_sum=0; out_count=0; out_ovf=0; accumulator, counter and last flag cleared. Reset mid-vector discards the partial sum with no output. The multiplier shares the system reset.
- All outputs are registered or decoded from state only; no combinational in→out path.
- States:
  - IDLE: in_ready=1. On in_valid: latch in_a→mul_m, in_b→mul_r and in_last → ISSUE. mul_m/mul_r hold until the product is captured, because the multiplier's ans depends on live m.
  - ISSUE: mul_start=1 for exactly one cycle if mul_ready=1 → WAIT_BUSY. If mul_ready=0, stay with mul_start=0.
  - WAIT_BUSY: wait for mul_ready=0 (multiplier accepted) → WAIT_DONE.
  - WAIT_DONE: on mul_ready=1, capture mul_ans → ACCUM.
  - ACCUM: acc ← acc + sign_extend(product, ACC_W); count ← count+1 (wraps at 2^CNT_W). If last → OUT, else → IDLE.
  - OUT: out_valid=1; out_sum/out_count/out_ovf stable. On out_ready → clear acc/count/ovf → IDLE. in_ready=0 throughout.
- Overflow: signed overflow of the ACC_W add sets out_ovf (sticky until vector output is accepted). Result handling depends on SATURATE_EN.
- in_ready is 0 in every state except IDLE; pairs presented meanwhile are held off, not dropped.
- out_ready asserted outside OUT is ignored.
- Single-element vector (in_last on first pair) is legal: count=1.
- Product −128×−128 = +16384 arrives as the multiplier's 16-bit signed value and is sign-extended as-is.

Optional Feature:
- Macro: BOOTH_DOT_SATURATE_EN.
- Defined: on overflow, acc clamps to +2^(ACC_W−1)−1 or −2^(ACC_W−1) per the sign of the true result, and stays clamped until a later addition brings it back in range. out_ovf is still set.
- Undefined: acc wraps modulo 2^ACC_W; out_ovf is set.

Test Plan:
- Reset then vector {(3,4),(−5,6),(7,−8) last} → out_valid with out_sum=−74, out_count=3, out_ovf=0; in_ready=0 until out_ready pulse, then 1.
- Single pair (−128,−128) last → out_sum=16384, count=1. Single pair (−128,127) last → out_sum=−16256.
- Backpressure: hold out_ready=0 for 20 cycles with next vector's in_valid=1 → out_* stable, in_ready=0, no pair consumed. Release → next vector is processed normally.
- Overflow with ACC_W=16: 3×(127,127) = 48387 exceeds 32767 → out_ovf=1. Without macro out_sum=−17149 (48387−65536); with BOOTH_DOT_SATURATE_EN out_sum=32767.
- Mid-operation reset: assert rst during WAIT_DONE of element 2 → next cycle in_ready=1, out_valid=0, mul_start=0. A new vector {(2,2) last} gives out_sum=4, count=1.
- Protocol: per element, mul_start is high exactly one cycle and only while mul_ready=1. mul_m/mul_r are constant from ISSUE through capture. With the companion multiplier, accept-to-accept is ≤16 cycles.
